ram_seq_master: RTL and testbench

Request sequencer upstream of the 16x8 RAM controller. Accepts single or burst read/write commands on a valid/ready command port, drives the RAM's chip-select, read, write, address and write-data pins, and returns read data on a valid/ready response stream. It converts the RAM's raw pin-level protocol into a stream interface for bus-side logic.

---
 rtl/ram_seq_pkg.sv | 13 +
 rtl/ram_seq_addr_gen.sv | 52 +++++
 rtl/ram_seq_master.sv | 118 +++++++++++
 tb/tb_ram_seq_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_seq_pkg.sv
// Shared types and default widths for the RAM request sequencer.
// Burst support is enabled by defining RAM_SEQ_BURST_EN.
package ram_seq_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_REQ  = 2'd2,
    RD_RESP = 2'd3
  } state_t;
endpackage

// File: rtl/ram_seq_addr_gen.sv
// Burst address/beat tracker for the RAM sequencer.
// With RAM_SEQ_BURST_EN undefined it collapses to a single address register and every beat is last.
module ram_seq_addr_gen
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

`ifdef RAM_SEQ_BURST_EN
  logic [ADDR_W-1:0] beats_left;

  // Address wraps naturally at 2^ADDR_W; load wins over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else if (load) begin
      cur_addr   <= load_addr;
      beats_left <= load_len;
    end else if (step) begin
      cur_addr   <= cur_addr + ADDR_W'(1);
      beats_left <= beats_left - ADDR_W'(1);
    end
  end

  assign last = (beats_left == '0);
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
    end else if (load) begin
      cur_addr <= load_addr;
    end
  end

  assign last = 1'b1;

  // Burst-only inputs are kept so the port list does not depend on the build.
  logic unused_burst;
  assign unused_burst = ^{step, load_len};
`endif

endmodule

// File: rtl/ram_seq_master.sv
// Stream-to-pin sequencer for the 16x8 RAM: commands in, RAM pins and read stream out.
// Define RAM_SEQ_BURST_EN to honour cmd_len; otherwise every command is a single beat.
module ram_seq_master
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              ram_cs,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;
  logic              cmd_fire;
  logic              wr_beat;
  logic              rd_beat;
  logic              finish;

  assign cmd_fire = cmd_valid && (state == IDLE) && !rst;
  assign wr_beat  = (state == WR) && wd_valid;
  assign rd_beat  = (state == RD_RESP) && rd_ready;
  assign finish   = last && (wr_beat || rd_beat);

  ram_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (cmd_fire),
    .step      ((wr_beat || rd_beat) && !last),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .cur_addr  (cur_addr),
    .last      (last)
  );

  // done is registered so it lands in the cycle after the final handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_fire) state_nxt = cmd_we ? WR : RD_REQ;
      WR:      if (finish) state_nxt = IDLE;
      RD_REQ:  state_nxt = RD_RESP;
      RD_RESP: if (rd_beat) state_nxt = last ? IDLE : RD_REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is forced low while rst is high so an aborted burst cannot touch the RAM.
  always_comb begin
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    rd_data   = '0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: cmd_ready = 1'b1;
        WR: begin
          wd_ready  = 1'b1;
          ram_write = wd_valid;
          ram_addr  = cur_addr;
          ram_wdata = wd_data;
        end
        RD_REQ: begin
          ram_read = 1'b1;
          ram_addr = cur_addr;
        end
        RD_RESP: begin
          rd_valid = 1'b1;
          rd_last  = last;
          rd_data  = ram_rdata;
        end
        default: ;
      endcase
    end
    ram_cs = ram_read || ram_write;
  end

endmodule

// File: tb/tb_ram_seq_master.sv
// Directed self-checking bench for ram_seq_master with a behavioural 16x8 registered-read RAM.
// Expectations follow RAM_SEQ_BURST_EN: bursts when defined, single beats otherwise.
module tb_ram_seq_master;

`ifdef RAM_SEQ_BURST_EN
  localparam int       NB2     = 2;
  localparam int       NB4     = 4;
  localparam int       NB16    = 16;
  localparam bit [7:0] EXP_A1  = 8'h44;
  localparam bit [7:0] EXP_A15 = 8'h8F;
`else
  localparam int       NB2     = 1;
  localparam int       NB4     = 1;
  localparam int       NB16    = 1;
  localparam bit [7:0] EXP_A1  = 8'h00;
  localparam bit [7:0] EXP_A15 = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [3:0] cmd_addr, cmd_len;
  logic       wd_valid, wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       ram_cs, ram_read, ram_write;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic       busy, done;

  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] d4  [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ram_seq_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .ram_cs    (ram_cs),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done)
  );

  // RAM model: synchronous write, registered read that holds until the next read.
  always @(posedge clk) begin
    if (ram_cs && ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_read)  ram_rdata     <= mem[ram_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic readOne(input logic [3:0] addr, input logic [7:0] exp_data, input string tag);
    applyStimulus(1'b0, addr, 4'd0);
    #1;
    checkOutput({tag, "_ram_read"}, {ram_cs, ram_read, ram_write}, 3'b110);
    checkOutput({tag, "_ram_addr"}, ram_addr, addr);
    rd_ready = 1'b1;
    cyc();
    checkOutput({tag, "_rd_valid"}, rd_valid, 1);
    checkOutput({tag, "_rd_data"}, rd_data, exp_data);
    checkOutput({tag, "_rd_last"}, rd_last, 1);
    cyc();
    rd_ready = 1'b0;
    #1;
    checkOutput({tag, "_done"}, done, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_outputs", {busy, done, rd_valid, rd_last, ram_cs, ram_read, ram_write}, 0);
    checkOutput("rst_addr", ram_addr, 0);

    // Single write to addr 3, then back-to-back read in the done cycle.
    applyStimulus(1'b1, 4'd3, 4'd0);
    wd_valid = 1'b1; wd_data = 8'hA5;
    #1;
    checkOutput("w1_pins", {ram_cs, ram_read, ram_write, wd_ready}, 4'b1011);
    checkOutput("w1_addr", ram_addr, 3);
    checkOutput("w1_wdata", ram_wdata, 8'hA5);
    cyc();
    wd_valid = 1'b0;
    #1;
    checkOutput("w1_done", {done, busy}, 2'b10);
    readOne(4'd3, 8'hA5, "r1");

    // Wrapping write burst with an idle wd_valid cycle first.
    cyc();
    applyStimulus(1'b1, 4'd14, 4'd3);
    #1;
    checkOutput("gap_pins", {ram_cs, ram_write, wd_ready, busy}, 4'b0011);
    cyc();
    for (int i = 0; i < NB4; i++) begin
      wd_valid = 1'b1; wd_data = d4[i];
      #1;
      checkOutput("bw_addr", ram_addr, (14 + i) % 16);
      checkOutput("bw_we", {ram_cs, ram_write, done}, 3'b110);
      cyc();
    end
    wd_valid = 1'b0;
    #1;
    checkOutput("bw_done", done, 1);

    // Read the same range back.
    applyStimulus(1'b0, 4'd14, 4'd3);
    for (int i = 0; i < NB4; i++) begin
      #1;
      checkOutput("br_req", {ram_cs, ram_read, ram_write, rd_valid}, 4'b1100);
      checkOutput("br_addr", ram_addr, (14 + i) % 16);
      rd_ready = 1'b1;
      cyc();
      checkOutput("br_data", rd_data, d4[i]);
      checkOutput("br_last", {rd_valid, rd_last}, {1'b1, i == NB4 - 1});
      cyc();
      rd_ready = 1'b0;
    end
    #1;
    checkOutput("br_done", done, 1);

    // Read backpressure: rd_ready low for 5 cycles on the first beat.
    applyStimulus(1'b0, 4'd14, 4'd1);
    for (int i = 0; i < NB2; i++) begin
      #1;
      checkOutput("bp_req_addr", ram_addr, (14 + i) % 16);
      cyc();
      if (i == 0) begin
        for (int k = 0; k < 5; k++) begin
          checkOutput("bp_hold", {rd_valid, ram_read, ram_cs}, 3'b100);
          checkOutput("bp_data", rd_data, 8'h11);
          cyc();
        end
      end
      rd_ready = 1'b1;
      #1;
      checkOutput("bp_beat", {rd_data, rd_last}, {d4[i], i == NB2 - 1});
      cyc();
      rd_ready = 1'b0;
    end
    #1;
    checkOutput("bp_done", done, 1);

    // Reset during the second beat of a 4-beat write.
    applyStimulus(1'b1, 4'd0, 4'd3);
    wd_valid = 1'b1; wd_data = 8'h5A;
    #1;
    checkOutput("rm_beat1", ram_write, 1);
    cyc();
    rst = 1'b1; wd_data = 8'h77;
    #1;
    checkOutput("rm_in_reset", {ram_cs, ram_write}, 0);
    cyc();
    rst = 1'b0;
    #1;
    checkOutput("rm_after", {busy, done, rd_valid, rd_last, ram_cs, ram_read, ram_write, wd_ready}, 0);
    checkOutput("rm_cmd_ready", cmd_ready, 1);
    cyc();
    wd_valid = 1'b0;
    #1;
    checkOutput("rm_no_done", done, 0);
    readOne(4'd0, 8'h5A, "rm_a0");
    readOne(4'd1, EXP_A1, "rm_a1");

    // cmd_valid held high across a write burst; next command taken in the done cycle.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd4; cmd_len = 4'd1;
    cyc();
    cmd_we = 1'b0; cmd_len = 4'd0;
    for (int i = 0; i < NB2; i++) begin
      wd_valid = 1'b1; wd_data = 8'h66 + 8'(i);
      #1;
      checkOutput("bz_cmd_ready", cmd_ready, 0);
      checkOutput("bz_addr", ram_addr, 4 + i);
      cyc();
    end
    wd_valid = 1'b0;
    #1;
    checkOutput("bz_done_ready", {done, cmd_ready}, 2'b11);
    cyc();
    cmd_valid = 1'b0;
    #1;
    checkOutput("bz_accept", {ram_read, ram_addr}, {1'b1, 4'd4});
    rd_ready = 1'b1;
    cyc();
    checkOutput("bz_rd_data", rd_data, 8'h66);
    cyc();
    rd_ready = 1'b0;
    #1;
    checkOutput("bz_rd_done", done, 1);

    // Full 16-beat burst from addr 0.
    applyStimulus(1'b1, 4'd0, 4'd15);
    for (int i = 0; i < NB16; i++) begin
      wd_valid = 1'b1; wd_data = 8'h80 + 8'(i);
      #1;
      checkOutput("f16_addr", ram_addr, i);
      checkOutput("f16_busy", {busy, done}, 2'b10);
      cyc();
    end
    wd_valid = 1'b0;
    #1;
    checkOutput("f16_done", {done, busy}, 2'b10);
    readOne(4'd0, 8'h80, "f16_a0");
    readOne(4'd15, EXP_A15, "f16_a15");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
